// File: rtl/warp_fetch.sv
// warp_fetch: AHB-lite instruction fetch manager for the dual-issue front end.
// Fetches one 64-bit word (two instruction slots) per single transfer and
// hands each pair downstream on a registered valid/ready interface.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_RESET | just out of reset, bus idle
// S_ADDR  | address phase, NONSEQ driven at req_addr
// S_DATA  | data phase, waiting for HREADY
// S_HOLD  | packet presented, waiting for downstream handshake
// S_FAULT | bus error delivered, parked until a redirect
module warp_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect_valid,
    input  logic [63:0] i_redirect_pc,
    output logic [63:0] o_ahb_haddr,
    output logic [1:0]  o_ahb_htrans,
    output logic [2:0]  o_ahb_hburst,
    output logic [2:0]  o_ahb_hsize,
    output logic [3:0]  o_ahb_hprot,
    output logic        o_ahb_hwrite,
    input  logic [63:0] i_ahb_hrdata,
    input  logic        i_ahb_hready,
    input  logic        i_ahb_hresp,
    output logic        o_output_valid,
    input  logic        i_output_ready,
    output logic [63:0] o_output_pc,
    output logic [63:0] o_output_insn,
    output logic [1:0]  o_output_mask,
    output logic        o_output_fault
);

    typedef enum logic [2:0] {
        S_RESET,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic [63:0] req_addr;
    logic        kill;
    logic        kill_next;
    logic        load_pkt;
    logic        load_fault;
    logic        handshake;

    logic [63:0] out_pc;
    logic [63:0] out_insn;
    logic [1:0]  out_mask;
    logic        out_fault;
    logic        out_valid;

    // Byte offset within a slot is meaningless for fetch.
    logic        unused_redirect_bits;
    assign unused_redirect_bits = ^i_redirect_pc[1:0];

    assign handshake = out_valid && i_output_ready;

    // Next-state, next-pc and packet-load decisions; redirect overrides last.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        kill_next  = kill;
        load_pkt   = 1'b0;
        load_fault = 1'b0;

        case (state)
            S_RESET: state_next = S_ADDR;
            S_ADDR: begin
                if (i_ahb_hready) state_next = S_DATA;
            end
            S_DATA: begin
                if (i_ahb_hready) begin
                    if (kill) begin
                        kill_next  = 1'b0;
                        state_next = S_ADDR;
                    end else if (i_ahb_hresp) begin
                        load_pkt   = 1'b1;
                        load_fault = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        load_pkt   = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    pc_next    = {pc[63:3] + 61'd1, 3'b000};
                    state_next = out_fault ? S_FAULT : S_ADDR;
                end
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_RESET;
        endcase

        if (i_redirect_valid) begin
            pc_next = {i_redirect_pc[63:2], 2'b00};
            case (state)
                // Address phase already committed on the bus: let it finish, drop its data.
                S_ADDR: kill_next = 1'b1;
                S_DATA: begin
                    if (i_ahb_hready) begin
                        kill_next  = 1'b0;
                        load_pkt   = 1'b0;
                        load_fault = 1'b0;
                        state_next = S_ADDR;
                    end else begin
                        kill_next = 1'b1;
                    end
                end
                default: state_next = S_ADDR;
            endcase
        end
    end

    // Control state: FSM, fetch pc, kill flag and the held transfer address.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_RESET;
            pc       <= {RESET_PC[63:2], 2'b00};
            kill     <= 1'b0;
            req_addr <= 64'h0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            kill  <= kill_next;
            if ((state_next == S_ADDR) && (state != S_ADDR)) begin
                req_addr <= {pc_next[63:3], 3'b000};
            end
        end
    end

    // Registered output packet; valid follows occupancy of S_HOLD.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_pc    <= 64'h0;
            out_insn  <= 64'h0;
            out_mask  <= 2'b00;
            out_fault <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_next == S_HOLD);
            if (load_pkt) begin
                out_pc    <= pc;
                out_insn  <= load_fault ? 64'h0 : i_ahb_hrdata;
                out_mask  <= load_fault ? 2'b00 : (pc[2] ? 2'b10 : 2'b11);
                out_fault <= load_fault;
            end
        end
    end

    assign o_ahb_haddr  = req_addr;
    assign o_ahb_htrans = (state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign o_ahb_hburst = 3'b000;
    assign o_ahb_hsize  = 3'b011;
    assign o_ahb_hprot  = 4'b0010;
    assign o_ahb_hwrite = 1'b0;

    assign o_output_valid = out_valid;
    assign o_output_pc    = out_pc;
    assign o_output_insn  = out_insn;
    assign o_output_mask  = out_mask;
    assign o_output_fault = out_fault;

endmodule

// File: tb/tb_warp_fetch.sv
// Bench for warp_fetch: behavioural AHB slave (data = addr ^ A5A5, optional
// wait states and ERROR), packet scoreboard, and one task per scenario.
module tb_warp_fetch;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] insn;
        logic [1:0]  mask;
        logic        fault;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        hwrite;
    logic [63:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_insn;
    logic [1:0]  out_mask;
    logic        out_fault;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // slave model state
    bit          dphase = 0;
    logic [63:0] daddr;
    int          waits_left = 0;
    bit          derr = 0;
    int          cfg_waits = 0;
    bit          err_en = 0;
    logic [63:0] err_addr = 64'h0;

    logic [63:0] nonseq_q[$];
    int          nonseq_cyc[$];
    int          dend_cyc[$];
    int          hs_cyc[$];
    pkt_t        exp_q[$];

    always #5 clk = ~clk;

    warp_fetch #(.RESET_PC(64'h1000)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .o_ahb_haddr     (haddr),
        .o_ahb_htrans    (htrans),
        .o_ahb_hburst    (hburst),
        .o_ahb_hsize     (hsize),
        .o_ahb_hprot     (hprot),
        .o_ahb_hwrite    (hwrite),
        .i_ahb_hrdata    (hrdata),
        .i_ahb_hready    (hready),
        .i_ahb_hresp     (hresp),
        .o_output_valid  (out_valid),
        .i_output_ready  (out_ready),
        .o_output_pc     (out_pc),
        .o_output_insn   (out_insn),
        .o_output_mask   (out_mask),
        .o_output_fault  (out_fault)
    );

    task automatic bus_model();
        if (rst) begin
            dphase = 0;
            hready = 1'b1;
            hresp  = 1'b0;
            hrdata = 64'h0;
            return;
        end
        if (dphase) begin
            hresp = derr;
            if (waits_left > 0) begin
                hready = 1'b0;
                hrdata = 64'h0;
                waits_left--;
            end else begin
                hready = 1'b1;
                hrdata = derr ? 64'h0 : (daddr ^ 64'hA5A5);
            end
        end else begin
            hready = 1'b1;
            hresp  = 1'b0;
            hrdata = 64'h0;
        end
        if (hready) begin
            if (dphase) dend_cyc.push_back(cyc);
            dphase = 0;
            if (htrans == 2'b10) begin
                dphase     = 1;
                daddr      = haddr;
                derr       = err_en && (haddr == err_addr);
                waits_left = derr ? 1 : cfg_waits;
                nonseq_q.push_back(haddr);
                nonseq_cyc.push_back(cyc);
            end
        end
    endtask

    // One clock: score a handshake the coming edge will take, then advance.
    task automatic step();
        pkt_t p;
        if (!rst && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_packet: got pc=%h insn=%h mask=%b fault=%b, required no packet",
                         out_pc, out_insn, out_mask, out_fault);
            end else begin
                p = exp_q.pop_front();
                if ({out_pc, out_insn, out_mask, out_fault} !== {p.pc, p.insn, p.mask, p.fault}) begin
                    errors++;
                    $display("FAIL packet: got pc=%h insn=%h mask=%b fault=%b, required pc=%h insn=%h mask=%b fault=%b",
                             out_pc, out_insn, out_mask, out_fault, p.pc, p.insn, p.mask, p.fault);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        bus_model();
    endtask

    task automatic push_pkt(input logic [63:0] pc, input logic [63:0] insn,
                            input logic [1:0] mask, input logic fault);
        pkt_t p;
        p.pc = pc; p.insn = insn; p.mask = mask; p.fault = fault;
        exp_q.push_back(p);
    endtask

    task automatic clear_logs();
        nonseq_q.delete();
        nonseq_cyc.delete();
        dend_cyc.delete();
        hs_cyc.delete();
    endtask

    task automatic do_redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic run_until_hs(input int n, input int bound, output bit ok);
        for (int i = 0; i < bound; i++) begin
            if (hs_cyc.size() >= n) break;
            step();
        end
        ok = (hs_cyc.size() >= n);
    endtask

    task automatic run_until_valid(input int bound, output bit ok);
        for (int i = 0; i < bound; i++) begin
            if (out_valid) break;
            step();
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b, required 00", htrans); end
        checks++; if (haddr !== 64'h0) begin errors++; $display("FAIL reset_haddr: got %h, required 0", haddr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
        checks++; if ({out_pc, out_insn, out_mask, out_fault} !== 131'h0) begin
            errors++; $display("FAIL reset_packet: got pc=%h insn=%h mask=%b fault=%b, required all 0", out_pc, out_insn, out_mask, out_fault);
        end
        checks++; if ({hburst, hsize, hprot, hwrite} !== {3'b000, 3'b011, 4'b0010, 1'b0}) begin
            errors++; $display("FAIL bus_constants: got burst=%b size=%b prot=%b write=%b, required 000 011 0010 0", hburst, hsize, hprot, hwrite);
        end
        clear_logs();
        rst = 1'b0;
        step();
        checks++; if ({htrans, haddr} !== {2'b10, 64'h1000}) begin
            errors++; $display("FAIL first_nonseq: got htrans=%b haddr=%h, required 10 / 1000", htrans, haddr);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        push_pkt(64'h1000, 64'h1000 ^ 64'hA5A5, 2'b11, 1'b0);
        push_pkt(64'h1008, 64'h1008 ^ 64'hA5A5, 2'b11, 1'b0);
        push_pkt(64'h1010, 64'h1010 ^ 64'hA5A5, 2'b11, 1'b0);
        out_ready = 1'b1;
        run_until_hs(3, 30, ok);
        out_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL seq_timeout: got %0d packets, required 3", hs_cyc.size()); end
        checks++; if (nonseq_q[0] !== 64'h1000) begin errors++; $display("FAIL seq_addr0: got %h, required 1000", nonseq_q[0]); end
        checks++; if (nonseq_q[1] !== 64'h1008) begin errors++; $display("FAIL seq_addr1: got %h, required 1008", nonseq_q[1]); end
        checks++; if (nonseq_q[2] !== 64'h1010) begin errors++; $display("FAIL seq_addr2: got %h, required 1010", nonseq_q[2]); end
        checks++; if (hs_cyc[0] - nonseq_cyc[0] !== 2) begin errors++; $display("FAIL seq_latency: got %0d, required 2", hs_cyc[0] - nonseq_cyc[0]); end
        checks++; if (hs_cyc[1] - hs_cyc[0] !== 3) begin errors++; $display("FAIL seq_rate01: got %0d, required 3", hs_cyc[1] - hs_cyc[0]); end
        checks++; if (hs_cyc[2] - hs_cyc[1] !== 3) begin errors++; $display("FAIL seq_rate12: got %0d, required 3", hs_cyc[2] - hs_cyc[1]); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL seq_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_unaligned();
        bit ok;
        run_until_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL unal_settle: got valid=%b, required 1", out_valid); end
        clear_logs();
        push_pkt(64'h2004, 64'h2000 ^ 64'hA5A5, 2'b10, 1'b0);
        push_pkt(64'h2008, 64'h2008 ^ 64'hA5A5, 2'b11, 1'b0);
        do_redirect(64'h2004);
        out_ready = 1'b1;
        run_until_hs(2, 30, ok);
        out_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL unal_timeout: got %0d packets, required 2", hs_cyc.size()); end
        checks++; if (nonseq_q[0] !== 64'h2000) begin errors++; $display("FAIL unal_addr0: got %h, required 2000", nonseq_q[0]); end
        checks++; if (nonseq_q[1] !== 64'h2008) begin errors++; $display("FAIL unal_addr1: got %h, required 2008", nonseq_q[1]); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL unal_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        run_until_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_settle: got valid=%b, required 1", out_valid); end
        clear_logs();
        cfg_waits = 3;
        push_pkt(64'h7000, 64'h7000 ^ 64'hA5A5, 2'b11, 1'b0);
        do_redirect(64'h7000);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            checks++; if (haddr !== 64'h7000) begin errors++; $display("FAIL bp_haddr_wait: got %h, required 7000", haddr); end
            if (out_valid) begin ok = 1; break; end
            step();
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got valid=%b, required 1", out_valid); end
        checks++; if (nonseq_q.size() !== 1) begin errors++; $display("FAIL bp_nonseq_count: got %0d, required 1", nonseq_q.size()); end
        checks++; if (dend_cyc[0] - nonseq_cyc[0] !== 4) begin errors++; $display("FAIL bp_dphase_len: got %0d, required 4", dend_cyc[0] - nonseq_cyc[0]); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({out_valid, out_pc, out_insn, out_mask, htrans, haddr} !==
                {1'b1, 64'h7000, 64'h7000 ^ 64'hA5A5, 2'b11, 2'b00, 64'h7000}) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b pc=%h insn=%h mask=%b htrans=%b haddr=%h, required 1 7000 %h 11 00 7000",
                         out_valid, out_pc, out_insn, out_mask, htrans, haddr, 64'h7000 ^ 64'hA5A5);
            end
        end
        cfg_waits = 0;
        out_ready = 1'b1;
        run_until_hs(1, 5, ok);
        out_ready = 1'b0;
        repeat (8) step();
        checks++; if (hs_cyc.size() !== 1) begin errors++; $display("FAIL bp_one_packet: got %0d, required 1", hs_cyc.size()); end
        checks++; if (nonseq_q.size() !== 2) begin errors++; $display("FAIL bp_nonseq_after: got %0d, required 2", nonseq_q.size()); end
        checks++; if (nonseq_q[1] !== 64'h7008) begin errors++; $display("FAIL bp_next_addr: got %h, required 7008", nonseq_q[1]); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        run_until_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rw_settle: got valid=%b, required 1", out_valid); end
        clear_logs();
        cfg_waits = 3;
        push_pkt(64'h4000, 64'h4000 ^ 64'hA5A5, 2'b11, 1'b0);
        do_redirect(64'h3000);
        cfg_waits = 0;
        step();
        checks++; if (hready !== 1'b0) begin errors++; $display("FAIL rw_in_wait: got hready=%b, required 0", hready); end
        do_redirect(64'h4000);
        out_ready = 1'b1;
        run_until_hs(1, 30, ok);
        out_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL rw_timeout: got %0d packets, required 1", hs_cyc.size()); end
        checks++; if (nonseq_q[0] !== 64'h3000) begin errors++; $display("FAIL rw_addr0: got %h, required 3000", nonseq_q[0]); end
        checks++; if (nonseq_q[1] !== 64'h4000) begin errors++; $display("FAIL rw_addr1: got %h, required 4000", nonseq_q[1]); end
        checks++; if (nonseq_cyc[1] !== dend_cyc[0] + 1) begin
            errors++; $display("FAIL rw_restart_cycle: got %0d, required %0d", nonseq_cyc[1], dend_cyc[0] + 1);
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rw_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_bus_error();
        bit ok;
        run_until_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL err_settle: got valid=%b, required 1", out_valid); end
        clear_logs();
        err_en   = 1;
        err_addr = 64'h5000;
        push_pkt(64'h5000, 64'h0, 2'b00, 1'b1);
        do_redirect(64'h5000);
        out_ready = 1'b1;
        run_until_hs(1, 30, ok);
        out_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL err_timeout: got %0d packets, required 1", hs_cyc.size()); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({htrans, out_valid} !== 3'b000) begin
                errors++; $display("FAIL err_parked: got htrans=%b valid=%b, required 00 0", htrans, out_valid);
            end
        end
        checks++; if (nonseq_q.size() !== 1) begin errors++; $display("FAIL err_nonseq_count: got %0d, required 1", nonseq_q.size()); end
        checks++; if (dend_cyc[0] - nonseq_cyc[0] !== 2) begin errors++; $display("FAIL err_dphase_len: got %0d, required 2", dend_cyc[0] - nonseq_cyc[0]); end
        err_en = 0;
        push_pkt(64'h6000, 64'h6000 ^ 64'hA5A5, 2'b11, 1'b0);
        do_redirect(64'h6000);
        out_ready = 1'b1;
        run_until_hs(2, 30, ok);
        out_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL err_resume_timeout: got %0d packets, required 2", hs_cyc.size()); end
        checks++; if (nonseq_q[1] !== 64'h6000) begin errors++; $display("FAIL err_resume_addr: got %h, required 6000", nonseq_q[1]); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL err_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap_reset();
        bit ok;
        run_until_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_settle: got valid=%b, required 1", out_valid); end
        clear_logs();
        push_pkt(64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8 ^ 64'hA5A5, 2'b11, 1'b0);
        push_pkt(64'h0, 64'hA5A5, 2'b11, 1'b0);
        do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
        out_ready = 1'b1;
        run_until_hs(2, 30, ok);
        out_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got %0d packets, required 2", hs_cyc.size()); end
        checks++; if (nonseq_q[0] !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL wrap_addr0: got %h, required fffffffffffffff8", nonseq_q[0]); end
        checks++; if (nonseq_q[1] !== 64'h0) begin errors++; $display("FAIL wrap_addr1: got %h, required 0", nonseq_q[1]); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL wrap_leftover: got %0d, required 0", exp_q.size()); end

        // reset in a waited data phase
        run_until_valid(20, ok);
        cfg_waits = 3;
        do_redirect(64'h8000);
        step();
        checks++; if ({htrans, haddr, hready} !== {2'b00, 64'h8000, 1'b0}) begin
            errors++; $display("FAIL rst_pre_data: got htrans=%b haddr=%h hready=%b, required 00 8000 0", htrans, haddr, hready);
        end
        rst = 1'b1;
        #1;
        checks++; if ({htrans, haddr, out_valid} !== {2'b00, 64'h0, 1'b0}) begin
            errors++; $display("FAIL rst_in_data: got htrans=%b haddr=%h valid=%b, required 00 0 0", htrans, haddr, out_valid);
        end
        cfg_waits = 0;
        repeat (2) step();
        rst = 1'b0;
        step();
        checks++; if ({htrans, haddr} !== {2'b10, 64'h1000}) begin
            errors++; $display("FAIL rst_restart: got htrans=%b haddr=%h, required 10 1000", htrans, haddr);
        end
        rst = 1'b1;
        #1;
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rst_in_addr: got htrans=%b, required 00", htrans); end
        repeat (2) step();
        rst = 1'b0;
        run_until_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_refetch: got valid=%b, required 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++; if ({out_valid, out_pc} !== {1'b0, 64'h0}) begin
            errors++; $display("FAIL rst_in_hold: got valid=%b pc=%h, required 0 0", out_valid, out_pc);
        end
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b0;
        hready         = 1'b1;
        hresp          = 1'b0;
        hrdata         = 64'h0;
        test_reset();
        test_sequential();
        test_unaligned();
        test_backpressure();
        test_redirect_wait();
        test_bus_error();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
